// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and arbitrates raw push-buttons into one-cycle press events.
// Optional feature macro BTN_HOLD_REPEAT_EN adds periodic repeat pulses while a single button is held.
module btn_conditioner #(
   parameter int NUM_BTN         = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn,
   input  logic               enable,
   output logic               press_pulse,
   output logic [1:0]         btn_code,
   output logic               multi_press,
   output logic [NUM_BTN-1:0] btn_stable
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} state_t;

   logic [NUM_BTN-1:0]            btn_norm;
   logic [NUM_BTN-1:0]            sync_p0;
   logic [NUM_BTN-1:0]            sync_p1;
   logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt;
   state_t                        state;
   logic [NUM_BTN-1:0]            held_mask;
   logic                          any_set;
   logic                          one_hot;
   logic                          extra_set;
   logic [1:0]                    code_of;

`ifdef BTN_HOLD_REPEAT_EN
   localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
   logic [RPT_W-1:0] rpt_cnt;
`else
   logic unused_rpt;
   assign unused_rpt = (REPEAT_CYCLES > 0);
`endif

   assign btn_norm = BTN_ACTIVE_LOW ? ~btn : btn;

   // Stage p0/p1: plain two-flop synchronizer, nothing between the flops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= btn_norm;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn_stable <= '0;
         db_cnt     <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (sync_p1[i] == btn_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               db_cnt[i]     <= '0;
               btn_stable[i] <= ~btn_stable[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      any_set   = |btn_stable;
      one_hot   = any_set && ((btn_stable & (btn_stable - 1'b1)) == '0);
      extra_set = |(btn_stable & ~held_mask);
      code_of   = 2'd0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (btn_stable[i]) code_of = 2'(i + 1);
      end
   end

   // Arbitration: LOCKOUT swallows disabled or multi-button presses until everything is released
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         held_mask   <= '0;
         press_pulse <= 1'b0;
         multi_press <= 1'b0;
         btn_code    <= 2'd0;
`ifdef BTN_HOLD_REPEAT_EN
         rpt_cnt     <= '0;
`endif
      end else begin
         press_pulse <= 1'b0;
         multi_press <= 1'b0;
         case (state)
            IDLE: begin
               if (any_set) begin
                  if (!enable) begin
                     state <= LOCKOUT;
                  end else if (one_hot) begin
                     press_pulse <= 1'b1;
                     btn_code    <= code_of;
                     held_mask   <= btn_stable;
                     state       <= HELD;
`ifdef BTN_HOLD_REPEAT_EN
                     rpt_cnt     <= '0;
`endif
                  end else begin
                     multi_press <= 1'b1;
                     state       <= LOCKOUT;
                  end
               end
            end
            HELD: begin
               if (!any_set) begin
                  state <= IDLE;
`ifdef BTN_HOLD_REPEAT_EN
                  rpt_cnt <= '0;
`endif
               end else if (extra_set) begin
                  multi_press <= enable;
                  state       <= LOCKOUT;
`ifdef BTN_HOLD_REPEAT_EN
                  rpt_cnt     <= '0;
               end else if (enable) begin
                  if (rpt_cnt == RPT_LAST) begin
                     rpt_cnt     <= '0;
                     press_pulse <= 1'b1;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
`endif
               end
            end
            LOCKOUT: begin
               if (!any_set) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity, checked each cycle
// against a window-based debounce model and a press-arbitration model.
module tb_btn_conditioner;

   localparam int D  = 4;
   localparam int R  = 16;
   localparam int HL = 16;
`ifdef BTN_HOLD_REPEAT_EN
   localparam bit REPEAT_ON = 1'b1;
`else
   localparam bit REPEAT_ON = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] btn;
   logic       enable;
   logic       press_pulse;
   logic [1:0] btn_code;
   logic       multi_press;
   logic [2:0] btn_stable;

   always #5 clock = ~clock;

   btn_conditioner #(
      .NUM_BTN(3), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .REPEAT_CYCLES(R)
   ) dut (
      .clock(clock), .reset(reset), .btn(btn), .enable(enable),
      .press_pulse(press_pulse), .btn_code(btn_code),
      .multi_press(multi_press), .btn_stable(btn_stable)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   // Reference model state
   bit [2:0] smp [HL];   // smp[0] = most recent pressed-level sample
   bit [2:0] m_stable;
   int       m_mode;     // 0 idle, 1 one button owned, 2 locked out
   int       m_owner;
   bit       m_pulse;
   bit       m_multi;
   bit [1:0] m_code;
   int       m_rpt;

   int pulse_cnt, multi_cnt, first_pulse, cyc_idx;

   task automatic model_reset();
      for (int k = 0; k < HL; k++) smp[k] = 3'b000;
      m_stable = 3'b000;
      m_mode   = 0;
      m_owner  = 0;
      m_pulse  = 1'b0;
      m_multi  = 1'b0;
      m_code   = 2'd0;
      m_rpt    = 0;
   endtask

   task automatic model_edge();
      bit [2:0] old_stable;
      int       nset;
      int       idx;
      bit       all_diff;
      old_stable = m_stable;
      nset       = $countones(old_stable);
      idx        = 0;
      for (int b = 0; b < 3; b++) if (old_stable[b]) idx = b;
      m_pulse = 1'b0;
      m_multi = 1'b0;
      case (m_mode)
         0: if (nset > 0) begin
               if (!enable) m_mode = 2;
               else if (nset == 1) begin
                  m_pulse = 1'b1; m_owner = idx; m_code = 2'(idx + 1); m_mode = 1; m_rpt = 0;
               end else begin
                  m_multi = 1'b1; m_mode = 2;
               end
            end
         1: if (nset == 0) m_mode = 0;
            else if (old_stable != (3'b001 << m_owner)) begin
               m_multi = enable; m_mode = 2;
            end else if (enable && REPEAT_ON) begin
               m_rpt++;
               if (m_rpt == R) begin m_pulse = 1'b1; m_rpt = 0; end
            end
         default: if (nset == 0) m_mode = 0;
      endcase
      // a level flips once the D synchronized samples seen at this edge all disagree with it
      for (int b = 0; b < 3; b++) begin
         all_diff = 1'b1;
         for (int k = 1; k <= D; k++) if (smp[k][b] == old_stable[b]) all_diff = 1'b0;
         if (all_diff) m_stable[b] = ~old_stable[b];
      end
      for (int k = HL - 1; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = ~btn;
   endtask

   task automatic mark();
      pulse_cnt   = 0;
      multi_cnt   = 0;
      first_pulse = -1;
      cyc_idx     = 0;
   endtask

   task automatic cyc(input logic [2:0] b, input logic en);
      btn    = b;
      enable = en;
      model_edge();
      @(negedge clock);
      cyc_idx++;
      chk("press_pulse", press_pulse, m_pulse);
      chk("multi_press", multi_press, m_multi);
      chk("btn_code", btn_code, m_code);
      chk("btn_stable", btn_stable, m_stable);
      chk("strobe_excl", press_pulse & multi_press, 0);
      if (press_pulse === 1'b1) begin
         pulse_cnt++;
         if (first_pulse < 0) first_pulse = cyc_idx;
      end
      if (multi_press === 1'b1) multi_cnt++;
   endtask

   task automatic run(input logic [2:0] b, input logic en, input int n);
      for (int i = 0; i < n; i++) cyc(b, en);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_pulse"}, press_pulse, 0);
      chk({tag, "_multi"}, multi_press, 0);
      chk({tag, "_code"}, btn_code, 0);
      chk({tag, "_stable"}, btn_stable, 0);
   endtask

   initial begin
      reset  = 1'b0;
      btn    = 3'b111;
      enable = 1'b1;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      chk_zero_outputs("reset");
      reset = 1'b1;

      // clean press of btn[0]
      mark();
      run(3'b110, 1'b1, 12);
      chk("clean_latency", first_pulse, 7);
      chk("clean_pulses", pulse_cnt, 1);
      chk("clean_code", btn_code, 1);
      mark();
      run(3'b111, 1'b1, 10);
      chk("release_pulses", pulse_cnt, 0);

      // bouncing btn[1], then settled
      mark();
      for (int t = 0; t < 5; t++) begin
         run(3'b101, 1'b1, 2);
         run(3'b111, 1'b1, 2);
      end
      chk("bounce_pulses", pulse_cnt, 0);
      mark();
      run(3'b101, 1'b1, 12);
      chk("settle_pulses", pulse_cnt, 1);
      chk("settle_code", btn_code, 2);
      run(3'b111, 1'b1, 12);

      // simultaneous btn[0]+btn[1]
      mark();
      run(3'b100, 1'b1, 12);
      chk("multi_count", multi_cnt, 1);
      chk("multi_no_pulse", pulse_cnt, 0);
      chk("multi_code_kept", btn_code, 2);
      run(3'b111, 1'b1, 12);
      mark();
      run(3'b011, 1'b1, 12);
      chk("btn2_pulses", pulse_cnt, 1);
      chk("btn2_code", btn_code, 3);
      run(3'b111, 1'b1, 12);

      // press while disabled, enable raised during the hold
      mark();
      run(3'b110, 1'b0, 10);
      run(3'b110, 1'b1, 10);
      chk("disabled_pulses", pulse_cnt, 0);
      chk("disabled_multi", multi_cnt, 0);
      run(3'b111, 1'b1, 12);
      mark();
      run(3'b110, 1'b1, 12);
      chk("reenable_pulses", pulse_cnt, 1);
      chk("reenable_code", btn_code, 1);
      run(3'b111, 1'b1, 12);

      // hold btn[2], add btn[0], then btn[1]
      mark();
      run(3'b011, 1'b1, 10);
      run(3'b010, 1'b1, 10);
      run(3'b000, 1'b1, 10);
      chk("add_pulses", pulse_cnt, 1);
      chk("add_multi", multi_cnt, 1);
      run(3'b111, 1'b1, 12);

      // long hold of btn[1]
      mark();
      run(3'b101, 1'b1, 57);
      chk("hold_pulses", pulse_cnt, REPEAT_ON ? 4 : 1);

      // reset in the middle of the hold
      reset = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      mark();
      run(3'b101, 1'b1, 12);
      chk("post_reset_latency", first_pulse, 7);
      chk("post_reset_code", btn_code, 2);
      run(3'b111, 1'b1, 12);

      // random activity
      for (int s = 0; s < 80; s++) begin
         logic [2:0] b;
         logic       en;
         int         len;
         b   = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
         en  = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 10);
         run(b, en, len);
      end
      run(3'b111, 1'b1, 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage directly upstream of the game FSM.
- Takes the raw board push-buttons and synchronizes, debounces and arbitrates them.
- Emits exactly one single-cycle press event per clean physical press, plus a 2-bit button code for comparison against the sequence value.
- Replaces the combinational press detect; rejects bounce, simultaneous presses and held buttons.

Parameters:
- NUM_BTN, 3, number of buttons; the design is fixed at 3, the parameter exists for checking only.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change (10 ms at 50 MHz).
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed.
- REPEAT_CYCLES, 25000000, hold-repeat interval; used only with the optional feature.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn  input  3  raw button inputs, asynchronous to clock
- enable  input  1  1 = the FSM accepts input; 0 = events suppressed
- press_pulse  output  1  one-cycle strobe on an accepted single press
- btn_code  output  2  code of the last accepted press: btn[0]=1, btn[1]=2, btn[2]=3; 0 = none since reset
- multi_press  output  1  one-cycle strobe when two or more buttons are pressed together
- btn_stable  output  3  debounced level, 1 = pressed, polarity normalized

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizers and btn_stable are set to released (000).
  - Debounce counters are 0 and the FSM is in IDLE.
  - press_pulse=0, multi_press=0, btn_code=0.
- Polarity: raw bits are inverted when BTN_ACTIVE_LOW=1, before synchronizing.
- Synchronizer: a 2-flop synchronizer per bit; no logic between the two flops.
- Debounce, one counter per bit, width ceil(log2(DEBOUNCE_CYCLES)):
  - If the synchronized bit equals btn_stable, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_stable toggles on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Latency: a raw press held clean reaches press_pulse=1 in the cycle after edge DEBOUNCE_CYCLES+3, counted from the first clock edge at which it is sampled.
- FSM states: IDLE, HELD, LOCKOUT. All outputs are registered.
- IDLE:
  - Exactly one btn_stable bit set and enable=1: press_pulse=1 for one cycle, btn_code takes that button's code, go to HELD.
  - Two or more bits set on the same cycle and enable=1: multi_press=1 for one cycle, btn_code unchanged, go to LOCKOUT.
  - Any bit set and enable=0: no strobe, go to LOCKOUT.
- HELD:
  - All released: go to IDLE.
  - An additional button becomes stable-pressed: multi_press=1 (only if enable=1), go to LOCKOUT.
  - Original button still held: no further events.
- LOCKOUT:
  - Stays until btn_stable==000 for one cycle, then goes to IDLE.
  - No strobes are generated in this state.
  - This prevents a button held across a disable, or a dropped multi-press, from firing later.
- press_pulse and multi_press are never high in the same cycle.
- A strobe lasts exactly one cycle regardless of hold time.
- btn_code holds its value between presses.
- Disable mid-press: enable falling while in HELD causes no event; the FSM returns to IDLE on release.
- Reset mid-operation: all state is discarded, and a press held through reset release must first be debounced from the released state.

Optional Feature:
- Macro: BTN_HOLD_REPEAT_EN.
- Defined:
  - In HELD with enable=1, a repeat counter counts clock cycles.
  - Every REPEAT_CYCLES cycles it emits another press_pulse with the same btn_code.
  - The counter clears on entry to HELD and on leaving it.
  - The first repeat comes REPEAT_CYCLES cycles after the initial pulse.
- Not defined: no repeat counter is synthesized, and a hold produces exactly one press_pulse.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16, BTN_ACTIVE_LOW=1):
- Reset then btn=3'b110 held clean -> exactly one press_pulse 7 cycles after first sample, btn_code=1, btn_stable=001; release -> IDLE, no pulse.
- btn[1] toggles every 2 cycles for 20 cycles, then stays low -> no event during bounce, then one press_pulse with btn_code=2.
- btn=3'b100 (btn[0] and btn[1] pressed on the same cycle) -> multi_press once, no press_pulse, btn_code keeps its previous value; release, press btn[2] -> press_pulse, btn_code=3.
- Press btn[0] with enable=0, raise enable while held -> no strobe until release; the next press -> press_pulse, btn_code=1.
- Hold btn[2], then press btn[0] -> press_pulse then multi_press; further presses are ignored until all are released.
- With BTN_HOLD_REPEAT_EN, hold btn[1] for 50 cycles after acceptance -> pulses at acceptance, +16, +32, +48; without the macro -> one pulse. Assert reset mid-hold -> all outputs 0 immediately.
